conv_pe_sequencer: RTL and testbench

Sequences a `conv_pe` over one output tile. On a start pulse it latches the tile geometry (width, height, input-channel-group count). It then issues one beat per cycle carrying row, column, channel and edge flags in row → channel → column order, so consecutive beats sweep columns of one channel and the PE's filter is reused across each sweep. It holds on backpressure, drains the PE pipeline after the last beat, and pulses done; it sits between the layer controller and `conv_pe`.

---
 rtl/conv_pe_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_conv_pe_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/conv_pe_sequencer.sv
// Tile sequencer for conv_pe: walks row -> channel -> column over one output tile,
// one registered beat per cycle, then drains the PE pipeline and pulses done.
module conv_pe_sequencer #(
    parameter int unsigned W_SIZE        = 9,
    parameter int unsigned W_CHANNEL     = 9,
    parameter int unsigned BM_DATA_DELAY = 2,
    parameter int unsigned MAC_DELAY     = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_start,
    input  logic [W_SIZE-1:0]    i_cfg_width,
    input  logic [W_SIZE-1:0]    i_cfg_height,
    input  logic [W_CHANNEL-1:0] i_cfg_chn,
    input  logic                 i_stall,
    output logic                 o_ctrl_data_run,
    output logic [W_SIZE-1:0]    o_row,
    output logic [W_SIZE-1:0]    o_col,
    output logic [W_CHANNEL-1:0] o_chn,
    output logic                 o_is_first_row,
    output logic                 o_is_last_row,
    output logic                 o_is_first_col,
    output logic                 o_is_last_col,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned STG     = BM_DATA_DELAY + MAC_DELAY;
    localparam int unsigned W_DRAIN = $clog2(STG + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [W_SIZE-1:0]    cfg_w_q, cfg_w_d;
    logic [W_SIZE-1:0]    cfg_h_q, cfg_h_d;
    logic [W_CHANNEL-1:0] cfg_c_q, cfg_c_d;
    logic [W_SIZE-1:0]    row_q, row_d;
    logic [W_SIZE-1:0]    col_q, col_d;
    logic [W_CHANNEL-1:0] chn_q, chn_d;
    logic [W_DRAIN-1:0]   drain_q, drain_d;

    logic                 run_q, run_d;
    logic [W_SIZE-1:0]    row_out_q, row_out_d;
    logic [W_SIZE-1:0]    col_out_q, col_out_d;
    logic [W_CHANNEL-1:0] chn_out_q, chn_out_d;
    logic                 first_row_q, first_row_d;
    logic                 last_row_q, last_row_d;
    logic                 first_col_q, first_col_d;
    logic                 last_col_q, last_col_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [W_SIZE-1:0]    w_max, h_max;
    logic [W_CHANNEL-1:0] c_max;
    logic                 col_last, row_last, chn_last;
    logic                 cfg_nonzero;

    // Only meaningful once a nonzero geometry has been latched.
    assign w_max    = cfg_w_q - W_SIZE'(1);
    assign h_max    = cfg_h_q - W_SIZE'(1);
    assign c_max    = cfg_c_q - W_CHANNEL'(1);
    assign col_last = (col_q == w_max);
    assign row_last = (row_q == h_max);
    assign chn_last = (chn_q == c_max);

    assign cfg_nonzero = (|i_cfg_width) && (|i_cfg_height) && (|i_cfg_chn);

    always_comb begin
        state_d     = state_q;
        cfg_w_d     = cfg_w_q;
        cfg_h_d     = cfg_h_q;
        cfg_c_d     = cfg_c_q;
        row_d       = row_q;
        col_d       = col_q;
        chn_d       = chn_q;
        drain_d     = drain_q;
        run_d       = 1'b0;
        row_out_d   = row_out_q;
        col_out_d   = col_out_q;
        chn_out_d   = chn_out_q;
        first_row_d = first_row_q;
        last_row_d  = last_row_q;
        first_col_d = first_col_q;
        last_col_d  = last_col_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    cfg_w_d = i_cfg_width;
                    cfg_h_d = i_cfg_height;
                    cfg_c_d = i_cfg_chn;
                    row_d   = '0;
                    col_d   = '0;
                    chn_d   = '0;
                    state_d = cfg_nonzero ? StRun : StDone;
                end
            end
            StRun: begin
                if (!i_stall) begin
                    run_d       = 1'b1;
                    row_out_d   = row_q;
                    col_out_d   = col_q;
                    chn_out_d   = chn_q;
                    first_row_d = (row_q == '0);
                    last_row_d  = row_last;
                    first_col_d = (col_q == '0);
                    last_col_d  = col_last;
                    // Column is innermost so the PE keeps one filter across a sweep.
                    if (col_last) begin
                        col_d = '0;
                        if (chn_last) begin
                            chn_d = '0;
                            if (row_last) begin
                                row_d   = '0;
                                drain_d = W_DRAIN'(STG);
                                state_d = StDrain;
                            end else begin
                                row_d = row_q + W_SIZE'(1);
                            end
                        end else begin
                            chn_d = chn_q + W_CHANNEL'(1);
                        end
                    end else begin
                        col_d = col_q + W_SIZE'(1);
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q - W_DRAIN'(1);
                if (drain_q == W_DRAIN'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status outputs are registered copies of the next state.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            cfg_c_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            chn_q       <= '0;
            drain_q     <= '0;
            run_q       <= 1'b0;
            row_out_q   <= '0;
            col_out_q   <= '0;
            chn_out_q   <= '0;
            first_row_q <= 1'b0;
            last_row_q  <= 1'b0;
            first_col_q <= 1'b0;
            last_col_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_w_q     <= cfg_w_d;
            cfg_h_q     <= cfg_h_d;
            cfg_c_q     <= cfg_c_d;
            row_q       <= row_d;
            col_q       <= col_d;
            chn_q       <= chn_d;
            drain_q     <= drain_d;
            run_q       <= run_d;
            row_out_q   <= row_out_d;
            col_out_q   <= col_out_d;
            chn_out_q   <= chn_out_d;
            first_row_q <= first_row_d;
            last_row_q  <= last_row_d;
            first_col_q <= first_col_d;
            last_col_q  <= last_col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_ctrl_data_run = run_q;
    assign o_row           = row_out_q;
    assign o_col           = col_out_q;
    assign o_chn           = chn_out_q;
    assign o_is_first_row  = first_row_q;
    assign o_is_last_row   = last_row_q;
    assign o_is_first_col  = first_col_q;
    assign o_is_last_col   = last_col_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed bench for conv_pe_sequencer: expected beats are queued at start and
// popped as the sequencer emits them; cycle timing comes from a small schedule model.
module tb_conv_pe_sequencer;

    localparam int STG = 6;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_start = 1'b0;
    logic [8:0] i_cfg_width = '0;
    logic [8:0] i_cfg_height = '0;
    logic [8:0] i_cfg_chn = '0;
    logic       i_stall = 1'b0;
    logic       o_ctrl_data_run;
    logic [8:0] o_row, o_col, o_chn;
    logic       o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col;
    logic       o_busy, o_done;

    int errors = 0;
    int checks = 0;
    logic [30:0] sb_q[$];
    logic [30:0] last_beat = '0;

    conv_pe_sequencer dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_start         (i_start),
        .i_cfg_width     (i_cfg_width),
        .i_cfg_height    (i_cfg_height),
        .i_cfg_chn       (i_cfg_chn),
        .i_stall         (i_stall),
        .o_ctrl_data_run (o_ctrl_data_run),
        .o_row           (o_row),
        .o_col           (o_col),
        .o_chn           (o_chn),
        .o_is_first_row  (o_is_first_row),
        .o_is_last_row   (o_is_last_row),
        .o_is_first_col  (o_is_first_col),
        .o_is_last_col   (o_is_last_col),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] pack(input int r, input int ch, input int col,
                                         input int w, input int h);
        logic [8:0] r9, c9, k9;
        r9 = 9'(r);
        c9 = 9'(ch);
        k9 = 9'(col);
        return {r9, c9, k9, r == 0, r == h - 1, col == 0, col == w - 1};
    endfunction

    function automatic logic [30:0] obs_beat();
        return {o_row, o_chn, o_col, o_is_first_row, o_is_last_row, o_is_first_col,
                o_is_last_col};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a tile in the current cycle (T) and check every cycle through done+2.
    // st_after/st_len: stall after that many beats; perturb: stray start at T+5;
    // abort_k: pull reset after the checks of cycle T+abort_k.
    task automatic run_tile(input int w, input int h, input int c, input int st_after,
                            input int st_len, input bit perturb, input int abort_k);
        int n, st_eff, t_done, last_k;
        bit exp_run, gap;
        n = w * h * c;
        for (int r = 0; r < h; r++)
            for (int ch = 0; ch < c; ch++)
                for (int col = 0; col < w; col++)
                    sb_q.push_back(pack(r, ch, col, w, h));
        st_eff = (st_len > 0 && n > st_after) ? st_len : 0;
        t_done = (n == 0) ? 1 : n + 1 + st_eff + STG;
        last_k = (abort_k > 0) ? abort_k : t_done + 2;

        i_cfg_width  = 9'(w);
        i_cfg_height = 9'(h);
        i_cfg_chn    = 9'(c);
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;

        for (int k = 1; k <= last_k; k++) begin
            gap = (st_eff > 0) && (k > st_after + 1) && (k <= st_after + 1 + st_len);
            exp_run = (n > 0) && (k >= 2) && (k <= n + 1 + st_eff) && !gap;
            check("run", 32'(o_ctrl_data_run), 32'(exp_run));
            check("done", 32'(o_done), 32'(k == t_done));
            check("busy", 32'(o_busy), 32'(k <= t_done));
            if (o_ctrl_data_run) begin
                if (sb_q.size() == 0) begin
                    check("extra_beat", 32'(1), 32'(0));
                end else begin
                    last_beat = sb_q.pop_front();
                    check("beat", 32'(obs_beat()), 32'(last_beat));
                end
            end else if (gap) begin
                check("gap_hold", 32'(obs_beat()), 32'(last_beat));
            end

            if (abort_k > 0 && k == abort_k) begin
                #2 rstn = 1'b0;
                #1;
                check("rst_run", 32'(o_ctrl_data_run), 32'(0));
                check("rst_beat", 32'(obs_beat()), 32'(0));
                check("rst_busy", 32'(o_busy), 32'(0));
                check("rst_done", 32'(o_done), 32'(0));
                tick();
                rstn = 1'b1;
                for (int j = 0; j < 10; j++) begin
                    tick();
                    check("post_rst_done", 32'(o_done), 32'(0));
                    check("post_rst_busy", 32'(o_busy), 32'(0));
                end
                sb_q.delete();
                return;
            end

            i_stall = (st_len > 0) && (k >= st_after + 1) && (k < st_after + 1 + st_len);
            if (perturb && k == 5) begin
                i_start      = 1'b1;
                i_cfg_width  = 9'd2;
                i_cfg_height = 9'd2;
                i_cfg_chn    = 9'd1;
            end else begin
                i_start = 1'b0;
            end
            tick();
        end
        i_stall = 1'b0;
        i_start = 1'b0;
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        sb_q.delete();
    endtask

    initial begin
        #12;
        check("reset_run", 32'(o_ctrl_data_run), 32'(0));
        check("reset_beat", 32'(obs_beat()), 32'(0));
        check("reset_busy", 32'(o_busy), 32'(0));
        check("reset_done", 32'(o_done), 32'(0));
        rstn = 1'b1;
        tick();
        tick();

        run_tile(4, 3, 2, 0, 0, 1'b0, 0);   // nominal, done at T+31
        run_tile(4, 3, 2, 5, 3, 1'b0, 0);   // 3-cycle stall, done at T+34
        run_tile(1, 1, 1, 0, 0, 1'b0, 0);   // single beat, done at T+8
        run_tile(0, 3, 2, 0, 0, 1'b0, 0);   // zero width, done at T+1
        run_tile(4, 3, 2, 0, 0, 1'b1, 0);   // stray start ignored
        run_tile(1, 2, 3, 0, 0, 1'b0, 0);   // single-column sweeps
        run_tile(3, 1, 2, 2, 1, 1'b0, 0);   // single row, short stall
        run_tile(4, 3, 2, 0, 0, 1'b0, 11);  // reset after beat 10
        run_tile(4, 3, 2, 0, 0, 1'b0, 0);   // full tile after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
